spi_cfg_sequencer: RTL and testbench

SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

---
 rtl/spi_cfg_sequencer_pkg.sv | 31 +++
 rtl/spi_cfg_sequencer_if.sv | 29 ++
 rtl/spi_cfg_sequencer_cmd_fifo.sv | 61 ++++++
 rtl/spi_cfg_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared definitions for the SPI configuration sequencer.
// Contents: command field widths, the commit address/key pair that turns a
// queued command into an apply-configuration strobe, FSM state encodings,
// and small helpers for splitting a packed command word.
package spi_cfg_sequencer_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CMD_W  = ADDR_W + DATA_W;

  // A command to this address is never written downstream; with the key
  // as data it requests a commit, with any other data it is discarded.
  localparam logic [ADDR_W-1:0] COMMIT_ADDR = 4'hF;
  localparam logic [DATA_W-1:0] COMMIT_KEY  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Packed command layout is {addr, data}.
  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] cmd_data(input logic [CMD_W-1:0] cmd);
    return cmd[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Command-in / config-write-out bus of the SPI configuration sequencer.
// Signals:
//   in_valid, in_addr, in_data : one-cycle command strobe from the frame decoder
//   cfg_valid, cfg_addr, cfg_data, cfg_ready : downstream register write handshake
// Modports:
//   master : environment side (drives commands and cfg_ready)
//   slave  : sequencer side (consumes commands, drives the write request)
interface spi_cfg_sequencer_if;
  import spi_cfg_sequencer_pkg::*;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              cfg_valid;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (
    output in_valid, in_addr, in_data, cfg_ready,
    input  cfg_valid, cfg_addr, cfg_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, cfg_ready,
    output cfg_valid, cfg_addr, cfg_data
  );

endinterface

// File: rtl/spi_cfg_sequencer_cmd_fifo.sv
// Synchronous command FIFO (12-bit entries, DEPTH deep).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write request and entry; ignored while full
//   pop, rd_data    : read request and head entry (rd_data valid while !empty)
//   full, empty     : occupancy flags
module cmd_fifo
  import spi_cfg_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] wr_data,
  input  logic             pop,
  output logic [CMD_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// SPI configuration sequencer: buffers decoded SPI commands and replays them
// as downstream register writes, one at a time, in arrival order. A command
// to COMMIT_ADDR carrying COMMIT_KEY becomes a one-cycle commit_pulse once
// every earlier command has finished.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : command input strobe and cfg_valid/cfg_ready write handshake
//   commit_pulse : one-cycle apply-configuration strobe
//   busy         : FIFO non-empty or a write/commit in progress
//   overflow     : sticky, a command was dropped on a full FIFO
//   timeout_err  : sticky, a write was abandoned after TIMEOUT unanswered cycles
//   err_clr      : clears both sticky flags
module spi_cfg_sequencer
  import spi_cfg_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  spi_cfg_sequencer_if.slave  bus,
  output logic                commit_pulse,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CMD_W-1:0] hold_r;
  logic [WAIT_W-1:0] wait_r;
  logic             pop_s;
  logic             timeout_hit_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CMD_W-1:0] fifo_rd_s;
  logic             push_s;
  logic             drop_s;
  logic             overflow_r;
  logic             timeout_err_r;

  // Fullness is judged at the start of the cycle, so a same-cycle pop does
  // not make room for the incoming command.
  assign push_s = bus.in_valid && !fifo_full_s;
  assign drop_s = bus.in_valid && fifo_full_s;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data ({bus.in_addr, bus.in_data}),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state decode; commands are consumed only from IDLE.
  always_comb begin
    state_s       = state_r;
    pop_s         = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          if (cmd_addr(fifo_rd_s) != COMMIT_ADDR) begin
            state_s = ST_ISSUE;
          end else if (cmd_data(fifo_rd_s) == COMMIT_KEY) begin
            state_s = ST_COMMIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.cfg_ready) begin
          state_s = ST_IDLE;
        end else if (wait_r == WAIT_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_COMMIT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Holding register and unanswered-cycle counter; the counter sits at zero
  // whenever no write is outstanding, so every ISSUE entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= '0;
      wait_r <= '0;
    end else begin
      if (pop_s) begin
        hold_r <= fifo_rd_s;
      end
      if (state_r != ST_ISSUE) begin
        wait_r <= '0;
      end else if (!bus.cfg_ready) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
    end
  end

  // Sticky error flags; a new error in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (drop_s)       overflow_r <= 1'b1;
      else if (err_clr) overflow_r <= 1'b0;
      if (timeout_hit_s) timeout_err_r <= 1'b1;
      else if (err_clr)  timeout_err_r <= 1'b0;
    end
  end

  assign bus.cfg_valid = (state_r == ST_ISSUE);
  assign bus.cfg_addr  = (state_r == ST_ISSUE) ? cmd_addr(hold_r) : '0;
  assign bus.cfg_data  = (state_r == ST_ISSUE) ? cmd_data(hold_r) : '0;
  assign commit_pulse  = (state_r == ST_COMMIT);
  assign busy          = !fifo_empty_s || (state_r != ST_IDLE);
  assign overflow      = overflow_r;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer (FIFO_DEPTH=4, TIMEOUT=8).
module tb_spi_cfg_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk;
  logic rst;
  logic err_clr;
  logic commit_pulse;
  logic busy;
  logic overflow;
  logic timeout_err;

  spi_cfg_sequencer_if bus();

  spi_cfg_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .commit_pulse (commit_pulse),
    .busy         (busy),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- downstream responder ----------------
  // ready_mode: 0 never ready, 1 always ready, 2 ready on 4th cycle of a request
  int ready_mode = 0;
  int rc = 0;
  always @(posedge clk) begin
    #2;
    if (bus.cfg_valid === 1'b1) rc++; else rc = 0;
    case (ready_mode)
      1:       bus.cfg_ready = 1'b1;
      2:       bus.cfg_ready = (rc >= 4);
      default: bus.cfg_ready = 1'b0;
    endcase
  end

  // ---------------- behavioural model ----------------
  logic [11:0] m_q[$];
  logic [11:0] m_cur;
  logic [11:0] m_cmd;
  bit m_writing, m_committing, m_ovf, m_tmo, m_full, m_new_ovf, m_new_tmo;
  int m_wait;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_writing = 0; m_committing = 0; m_wait = 0; m_ovf = 0; m_tmo = 0; m_cur = '0;
    end else begin
      m_full    = (m_q.size() == DEPTH);
      m_new_ovf = bus.in_valid && m_full;
      m_new_tmo = 0;
      if (m_committing) begin
        m_committing = 0;
      end else if (m_writing) begin
        if (bus.cfg_ready) m_writing = 0;
        else begin
          m_wait++;
          if (m_wait == TMO) begin m_writing = 0; m_new_tmo = 1; end
        end
      end else if (m_q.size() > 0) begin
        m_cmd = m_q.pop_front();
        if (m_cmd[11:8] != 4'hF) begin m_writing = 1; m_cur = m_cmd; m_wait = 0; end
        else if (m_cmd[7:0] == 8'hA5) m_committing = 1;
      end
      if (bus.in_valid && !m_full) m_q.push_back({bus.in_addr, bus.in_data});
      m_ovf = m_new_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_tmo = m_new_tmo ? 1'b1 : (err_clr ? 1'b0 : m_tmo);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_valid", 32'(bus.cfg_valid), 32'(m_writing));
      check("cfg_addr", 32'(bus.cfg_addr), m_writing ? 32'(m_cur[11:8]) : 32'd0);
      check("cfg_data", 32'(bus.cfg_data), m_writing ? 32'(m_cur[7:0]) : 32'd0);
      check("commit_pulse", 32'(commit_pulse), 32'(m_committing));
      check("busy", 32'(busy), 32'((m_q.size() > 0) || m_writing || m_committing));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout_err", 32'(timeout_err), 32'(m_tmo));
    end
  end

  // ---------------- observation logs ----------------
  logic [11:0] wlog[$];
  int wlog_cyc[$];
  int runs[$];
  int run_len = 0;
  int commits = 0;
  int commit_cyc = 0;
  always @(negedge clk) begin
    if (bus.cfg_valid === 1'b1 && bus.cfg_ready === 1'b1) begin
      wlog.push_back({bus.cfg_addr, bus.cfg_data});
      wlog_cyc.push_back(cyc);
    end
    if (commit_pulse === 1'b1) begin commits++; commit_cyc = cyc; end
    if (bus.cfg_valid === 1'b1) run_len++;
    else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wlog.delete(); wlog_cyc.delete(); runs.delete(); commits = 0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin step(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [3:0] a, input logic [7:0] d);
    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_data = d;
    step();
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.cfg_ready = 1'b0;
    repeat (2) step();
    // Reset state
    check("rst cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst flags", 32'({overflow, timeout_err, commit_pulse}), 32'd0);
    rst = 1'b0;
    chk_en = 1;
    step();

    // Single write 3/5C with cfg_ready tied high: cfg_valid at N+2 for one cycle
    ready_mode = 1;
    step();
    send(4'h3, 8'h5C);
    check("lat N+1 cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("lat N+1 busy", 32'(busy), 32'd1);
    step();
    check("lat N+2 cfg_valid", 32'(bus.cfg_valid), 32'd1);
    check("lat N+2 cfg_addr", 32'(bus.cfg_addr), 32'h3);
    check("lat N+2 cfg_data", 32'(bus.cfg_data), 32'h5C);
    step();
    check("lat N+3 cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("lat N+3 busy", 32'(busy), 32'd0);

    // Overflow: ready held low. The first command is popped into the write
    // stage, so the sixth back-to-back strobe is the first one to meet a full FIFO.
    ready_mode = 0;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 4'(i); bus.in_data = 8'(8'h10 * i + 1);
      step();
      if (i == 4) check("ovf after 5", 32'(overflow), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("ovf after 6", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf cleared", 32'(overflow), 32'd0);
    wait_idle(120, "ovf drain");
    check("ovf no transfers", 32'(wlog.size()), 32'd0);
    check("ovf timeouts", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("errclr both", 32'({overflow, timeout_err}), 32'd0);

    // Ordered writes then commit, ready after 3 cycles each
    ready_mode = 2;
    clear_logs();
    bus.in_valid = 1'b1; bus.in_addr = 4'h1; bus.in_data = 8'h11; step();
    bus.in_addr = 4'h2; bus.in_data = 8'h22; step();
    bus.in_addr = 4'hF; bus.in_data = 8'hA5; step();
    bus.in_valid = 1'b0;
    wait_idle(60, "commit drain");
    check("seq count", 32'(wlog.size()), 32'd2);
    check("seq w0", 32'(wlog[0]), 32'h111);
    check("seq w1", 32'(wlog[1]), 32'h222);
    check("seq run0", 32'(runs[0]), 32'd4);
    check("seq commits", 32'(commits), 32'd1);
    check("seq commit after", 32'(commit_cyc > wlog_cyc[1]), 32'd1);

    // Non-key command to the commit address is discarded
    clear_logs();
    send(4'hF, 8'h00);
    wait_idle(10, "discard drain");
    check("discard writes", 32'(wlog.size() + runs.size()), 32'd0);
    check("discard commits", 32'(commits), 32'd0);

    // Timeout then the next queued command issues
    ready_mode = 0;
    clear_logs();
    bus.in_valid = 1'b1; bus.in_addr = 4'hA; bus.in_data = 8'hB0; step();
    bus.in_addr = 4'h4; bus.in_data = 8'h44; step();
    bus.in_valid = 1'b0;
    begin
      int n = 0;
      while (timeout_err !== 1'b1 && n < 40) begin step(); n++; end
    end
    check("tmo flag", 32'(timeout_err), 32'd1);
    ready_mode = 1;
    wait_idle(20, "tmo drain");
    check("tmo run", 32'(runs[0]), 32'd8);
    check("tmo next count", 32'(wlog.size()), 32'd1);
    check("tmo next cmd", 32'(wlog[0]), 32'h444);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Reset during ISSUE with two commands queued
    ready_mode = 0;
    clear_logs();
    bus.in_valid = 1'b1; bus.in_addr = 4'h6; bus.in_data = 8'h66; step();
    bus.in_addr = 4'h7; bus.in_data = 8'h77; step();
    bus.in_addr = 4'h8; bus.in_data = 8'h88; step();
    check("pre-rst issuing", 32'(bus.cfg_valid), 32'd1);
    rst = 1'b1; bus.in_addr = 4'h9; bus.in_data = 8'h99;
    step();
    check("rst mid cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid flags", 32'({overflow, timeout_err, commit_pulse}), 32'd0);
    rst = 1'b0; bus.in_valid = 1'b0;
    step();
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst writes", 32'(wlog.size()), 32'd0);
    repeat (3) step();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
